// File: rtl/never8_ctrl.sv
// never8_ctrl: multi-cycle controller for an 8-bit accumulator machine.
// Drives an external ALU, instruction fetch port and a valid/ready output port.
module never8_ctrl #(
  parameter logic [4:0] RESET_PC = 5'd0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       instr_req,
  output logic [4:0] instr_addr,
  input  logic       instr_ack,
  input  logic [7:0] instr_data,
  output logic [2:0] alu_opcode,
  output logic [4:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  input  logic       alu_z,
  input  logic       alu_c,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  input  logic       run,
  output logic       halted,
  output logic [7:0] acc,
  output logic       zflag,
  output logic       cflag
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, OUTW, HALT
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] out_q, out_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  // Keeps instr_req low while rst is high and until the first edge after it.
  logic       live_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'd0;
      acc_q   <= 8'd0;
      out_q   <= 8'd0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      FETCH: begin
        if (live_q && instr_ack) begin
          ir_d    = instr_data;
          pc_d    = pc_q + 5'd1;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        unique case (ir_q[7:5])
          3'b000, 3'b001: begin
            acc_d = alu_result;
            z_d   = alu_z;
            c_d   = alu_c;
          end
          3'b010: acc_d = {3'b000, ir_q[4:0]};
          3'b011: pc_d = ir_q[4:0];
          3'b100: if (z_q) pc_d = ir_q[4:0];
          3'b101: if (c_q) pc_d = ir_q[4:0];
          3'b110: begin
            out_d   = acc_q;
            state_d = OUTW;
          end
          3'b111: state_d = HALT;
        endcase
      end
      OUTW: if (out_ready) state_d = FETCH;
      HALT: if (run) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  assign instr_req  = live_q && (state_q == FETCH);
  assign instr_addr = pc_q;
  assign out_valid  = (state_q == OUTW);
  assign out_data   = out_q;
  assign halted     = (state_q == HALT);
  assign alu_opcode = {2'b00, ir_q[5]};
  assign alu_a      = ir_q[4:0];
  assign alu_b      = acc_q;
  assign acc        = acc_q;
  assign zflag      = z_q;
  assign cflag      = c_q;

endmodule

// File: tb/tb_never8_ctrl.sv
// Directed bench for never8_ctrl: instruction table plus
// hand-written stall, halt and reset sequences.
module tb_never8_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_req;
  logic [4:0] instr_addr;
  logic       instr_ack;
  logic [7:0] instr_data;
  logic [2:0] alu_opcode;
  logic [4:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_z;
  logic       alu_c;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       run;
  logic       halted;
  logic [7:0] acc;
  logic       zflag;
  logic       cflag;

  never8_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_ack(instr_ack), .instr_data(instr_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_z(alu_z), .alu_c(alu_c),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .run(run), .halted(halted), .acc(acc),
    .zflag(zflag), .cflag(cflag)
  );

  always #5 clk = ~clk;

  // Reference ALU: b + a or b - a, carry is the ninth bit (borrow on SUB).
  logic [8:0] alu_t;
  always_comb begin
    alu_t = 9'd0;
    if (alu_opcode == 3'b001)
      alu_t = {1'b0, alu_b} - {4'b0, alu_a};
    else
      alu_t = {1'b0, alu_b} + {4'b0, alu_a};
    alu_result = alu_t[7:0];
    alu_c      = alu_t[8];
    alu_z      = (alu_t[7:0] == 8'd0);
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic feed(input logic [7:0] ins, input int dly,
                      input logic [4:0] addr);
    int n;
    logic stab;
    n = 0;
    while (!instr_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", instr_req, 1);
    chk("fetch_addr", instr_addr, addr);
    stab = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (!(instr_req && instr_addr == addr)) stab = 1'b0;
    end
    chk("fetch_hold", stab, 1);
    instr_ack  = 1'b1;
    instr_data = ins;
    @(negedge clk);
    instr_ack  = 1'b0;
  endtask

  // Waits for the next fetch or HALT; a stray ack with junk data is
  // presented while decoding and must be ignored.
  task automatic settle(output int lat, output int vcyc,
                        output logic [7:0] od);
    lat  = 1;
    vcyc = 0;
    od   = 8'h00;
    instr_ack  = 1'b1;
    instr_data = 8'hFF;
    @(negedge clk);
    instr_ack  = 1'b0;
    lat = 2;
    while (!instr_req && !halted && lat < 30) begin
      if (out_valid && out_ready) begin
        vcyc++;
        od = out_data;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [7:0] ins;
    int         dly;
    logic [4:0] addr;
    logic [7:0] acc;
    logic       z;
    logic       c;
    int         lat;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int lat, vcyc, n;
    logic [7:0] od;
    logic stab;
    logic is_out;

    tbl = '{
      '{8'h43, 0,  5'd0,  8'h03, 1'b0, 1'b0, 3},
      '{8'h23, 2,  5'd1,  8'h00, 1'b1, 1'b0, 3},
      '{8'h8A, 0,  5'd2,  8'h00, 1'b1, 1'b0, 3},
      '{8'h60, 0,  5'd10, 8'h00, 1'b1, 1'b0, 3},
      '{8'h43, 4,  5'd0,  8'h03, 1'b1, 1'b0, 3},
      '{8'h22, 0,  5'd1,  8'h01, 1'b0, 1'b0, 3},
      '{8'h8A, 0,  5'd2,  8'h01, 1'b0, 1'b0, 3},
      '{8'h45, 0,  5'd3,  8'h05, 1'b0, 1'b0, 3},
      '{8'h03, 0,  5'd4,  8'h08, 1'b0, 1'b0, 3},
      '{8'hC0, 0,  5'd5,  8'h08, 1'b0, 1'b0, 4},
      '{8'h5F, 0,  5'd6,  8'h1F, 1'b0, 1'b0, 3},
      '{8'h1F, 0,  5'd7,  8'h3E, 1'b0, 1'b0, 3},
      '{8'h1F, 0,  5'd8,  8'h5D, 1'b0, 1'b0, 3},
      '{8'h1F, 0,  5'd9,  8'h7C, 1'b0, 1'b0, 3},
      '{8'h1F, 0,  5'd10, 8'h9B, 1'b0, 1'b0, 3},
      '{8'h1F, 0,  5'd11, 8'hBA, 1'b0, 1'b0, 3},
      '{8'h1F, 0,  5'd12, 8'hD9, 1'b0, 1'b0, 3},
      '{8'h1F, 0,  5'd13, 8'hF8, 1'b0, 1'b0, 3},
      '{8'h08, 0,  5'd14, 8'h00, 1'b1, 1'b1, 3},
      '{8'hA0, 0,  5'd15, 8'h00, 1'b1, 1'b1, 3},
      '{8'h47, 0,  5'd0,  8'h07, 1'b1, 1'b1, 3},
      '{8'h94, 0,  5'd1,  8'h07, 1'b1, 1'b1, 3},
      '{8'h00, 0,  5'd20, 8'h07, 1'b0, 1'b0, 3},
      '{8'hA2, 0,  5'd21, 8'h07, 1'b0, 1'b0, 3}
    };

    rst        = 1'b1;
    instr_ack  = 1'b0;
    instr_data = 8'h00;
    out_ready  = 1'b1;
    run        = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", instr_req, 0);
    chk("rst_addr", instr_addr, 0);
    chk("rst_acc", acc, 0);
    chk("rst_flags", {zflag, cflag}, 0);
    chk("rst_out", {out_valid, out_data}, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_first_req", instr_req, 1);

    foreach (tbl[i]) begin
      is_out = (tbl[i].ins[7:5] == 3'b110);
      feed(tbl[i].ins, tbl[i].dly, tbl[i].addr);
      settle(lat, vcyc, od);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_acc", i), acc, tbl[i].acc);
      chk($sformatf("v%0d_z", i), zflag, tbl[i].z);
      chk($sformatf("v%0d_c", i), cflag, tbl[i].c);
      chk($sformatf("v%0d_xfer", i), vcyc, {31'd0, is_out});
      if (is_out) chk($sformatf("v%0d_odata", i), od, tbl[i].acc);
    end

    // OUT with consumer stalled for three cycles
    out_ready = 1'b0;
    feed(8'hC0, 0, 5'd22);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", out_valid, 1);
    chk("stall_data", out_data, 8'h07);
    stab = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!(out_valid && out_data == 8'h07 && !instr_req)) stab = 1'b0;
    end
    chk("stall_hold", stab, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_done", {out_valid, instr_req}, 2'b01);
    chk("stall_addr", instr_addr, 5'd23);

    // HLT at address 31 wraps pc to 0
    feed(8'h7F, 0, 5'd23);
    settle(lat, vcyc, od);
    feed(8'hE0, 0, 5'd31);
    settle(lat, vcyc, od);
    chk("hlt_halted", halted, 1);
    chk("hlt_pc", instr_addr, 5'd0);
    repeat (3) @(negedge clk);
    chk("hlt_stay", {halted, instr_req}, 2'b10);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("run_resume", {halted, instr_req}, 2'b01);
    chk("run_addr", instr_addr, 5'd0);

    // Reset while OUT is waiting on the consumer
    feed(8'h49, 0, 5'd0);
    settle(lat, vcyc, od);
    chk("pre_rst_acc", acc, 8'h09);
    out_ready = 1'b0;
    feed(8'hC0, 0, 5'd1);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("outw_data", out_data, 8'h09);
    rst = 1'b1;
    #1;
    chk("rst_outw_valid", out_valid, 0);
    chk("rst_outw_acc", acc, 0);
    chk("rst_outw_addr", instr_addr, 0);
    chk("rst_outw_req", instr_req, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_outw_refetch", {instr_req, out_valid}, 2'b10);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/never8_ctrl.md
NEVER8_CTRL -- requirements
Module: never8_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 5'd0, the PC value loaded on reset.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: instr_req  out  1  fetch request; instr_addr  out  5  fetch address (= pc); instr_ack  in  1  fetch data valid; instr_data  in  8  instruction {op[7:5], imm[4:0]}.
REQ-004 SHALL have ports: alu_opcode  out  3  to ALU opcode; alu_a  out  5  to ALU a; alu_b  out  8  to ALU b; alu_result  in  8  ALU data_out; alu_z  in  1  ALU zflag; alu_c  in  1  ALU carry.
REQ-005 SHALL have ports: out_valid  out  1  output-port data valid; out_data  out  8  output-port data; out_ready  in  1  consumer accepts.
REQ-006 SHALL have ports: run  in  1  resume from HALT; halted  out  1  high in HALT; acc  out  8  accumulator; zflag  out  1  zero flag; cflag  out  1  carry flag.

Function
REQ-007 SHALL implement states FETCH, DECODE, EXEC, OUTW, HALT; one state per cycle unless stalled.
REQ-008 FETCH SHALL drive instr_req=1, instr_addr=pc; hold both stable until instr_ack=1; on ack, load ir<=instr_data, pc<=pc+1 (5-bit wrap, 31->0), go DECODE.
REQ-009 instr_data SHALL be sampled only in the cycle instr_ack=1 while in FETCH; instr_ack in any other state SHALL be ignored.
REQ-010 DECODE SHALL last exactly one cycle, then go EXEC.
REQ-011 EXEC SHALL drive alu_opcode={2'b00, ir[5]}, alu_a=ir[4:0], alu_b=acc; ALU outputs are combinational and SHALL be captured at the end of EXEC.
REQ-012 Opcode 000 ADD / 001 SUB: acc<=alu_result, zflag<=alu_z, cflag<=alu_c; next FETCH.
REQ-013 Opcode 010 LDI: acc<={3'b000, imm}; flags unchanged; next FETCH.
REQ-014 Opcode 011 JMP: pc<=imm; next FETCH.
REQ-015 Opcode 100 JZ: pc<=imm if zflag=1, else pc unchanged; next FETCH.
REQ-016 Opcode 101 JC: pc<=imm if cflag=1, else pc unchanged; next FETCH.
REQ-017 Opcode 110 OUT: out_data<=acc; go OUTW.
REQ-018 OUTW SHALL hold out_valid=1 with out_data stable until out_ready=1; transfer completes in the cycle out_valid and out_ready are both high; next FETCH.
REQ-019 Opcode 111 HLT: go HALT; halted=1 while in HALT; pc already points past HLT.
REQ-020 HALT SHALL go FETCH on run=1; run SHALL be ignored in all other states.
REQ-021 Only ADD/SUB SHALL modify zflag/cflag; only ADD/SUB/LDI SHALL modify acc.
REQ-022 instr_req, out_valid, halted SHALL be registered or decoded from state only (no combinational path from any input).
REQ-023 Minimum latency per instruction (ack in first FETCH cycle): 3 cycles; OUT 4 cycles with out_ready already high.
REQ-024 Outside EXEC, alu_opcode/alu_a/alu_b SHALL still reflect ir/acc (no gating); the ALU result SHALL have no effect outside EXEC.

Reset
REQ-025 rst=1 SHALL asynchronously force: state=FETCH, pc=RESET_PC, ir=0, acc=0, zflag=0, cflag=0, out_valid=0, out_data=0, halted=0.
REQ-026 instr_req SHALL be 0 while rst=1 and SHALL assert in the first clock cycle after rst deasserts.
REQ-027 Reset asserted mid-fetch, mid-OUTW, or in HALT SHALL abandon the operation with no acc/flag/pc update and no completed output transfer.

Verification
REQ-028 Program LDI 5; ADD 3; OUT with out_ready=1, ack same cycle -> out_data=8'd8 at out_valid, zflag=0, cflag=0.
REQ-029 LDI 3; SUB 3; JZ 10 -> acc=0, zflag=1, next instr_addr=10; repeat with SUB 2 -> JZ not taken, instr_addr=3.
REQ-030 LDI 31; ADD 31 repeated until acc wraps (acc=8'd248 + ADD 8) -> acc=0, cflag=1, zflag=1; following JC 0 -> instr_addr=0.
REQ-031 Fetch with instr_ack delayed 4 cycles -> instr_req and instr_addr stable all 4 cycles, single pc increment; OUT with out_ready low 3 cycles -> out_valid, out_data stable, one transfer.
REQ-032 HLT at address 31 -> halted=1, pc=0, no instr_req; run pulse -> fetch from address 0; rst during OUTW -> out_valid=0 immediately, acc=0, instr_addr=RESET_PC.
